// File: rtl/neuron_accumulator_if.sv
// ---------------------------------------------------------------------------
// neuron_accumulator_if
// Purpose : bundles the product stream and the activation stream of the
//           neuron accumulator into one interface.
// Signals :
//   in_valid  / in_ready   product handshake (producer -> accumulator)
//   in_data   [15:0]       signed product
//   bias      [15:0]       signed neuron bias, taken while the sum is finished
//   out_valid / out_ready  activation handshake (accumulator -> consumer)
//   out_data  [7:0]        unsigned activation
//   out_sat                activation was clipped to 255
// Modports: master drives products and consumes activations (environment);
//           slave is the accumulator itself.
// ---------------------------------------------------------------------------
interface neuron_accumulator_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sat;

    modport master (
        output in_valid, in_data, bias, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, bias, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neuron_accumulator.sv
// ---------------------------------------------------------------------------
// neuron_accumulator
// Purpose : sums NUM_INPUTS signed 16-bit products for one neuron, adds the
//           neuron bias, applies ReLU, rescales by an arithmetic right shift
//           of SHIFT and saturates to an unsigned 8-bit activation.
// Ports   :
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    neuron_accumulator_if.slave (product in, bias, activation out)
// Operation: ACC collects products, FIN forms the activation in one cycle,
//           OUT holds it until the consumer takes it. Accumulation and output
//           never overlap.
// ---------------------------------------------------------------------------
module neuron_accumulator #(
    parameter int NUM_INPUTS = 8,
    parameter int ACC_W      = 24,
    parameter int SHIFT      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    neuron_accumulator_if.slave  bus
);

    localparam int                CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_FIN,
        ST_OUT
    } state_t;

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   count_q,    count_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [7:0]         out_data_q, out_data_d;
    logic               out_sat_q,  out_sat_d;

    // Biased sum carries one extra bit so the sign survives the bias add.
    logic [ACC_W:0]     biased_sum;
    logic [ACC_W:0]     scaled;

    assign biased_sum = {acc_q[ACC_W-1], acc_q}
                      + {{(ACC_W + 1 - 16){bus.bias[15]}}, bus.bias};
    // Only consulted when biased_sum is non-negative, so a logical shift
    // gives the same result as an arithmetic one.
    assign scaled     = biased_sum >> SHIFT;

    // Next-state and datapath: accumulate, finish the neuron, then hold.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;

        case (state_q)
            ST_ACC: begin
                if (bus.in_valid) begin
                    acc_d = acc_q + {{(ACC_W - 16){bus.in_data[15]}}, bus.in_data};
                    if (count_q == LAST) begin
                        count_d = '0;
                        state_d = ST_FIN;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_FIN: begin
                if (biased_sum[ACC_W]) begin
                    out_data_d = 8'd0;
                    out_sat_d  = 1'b0;
                end else if (|scaled[ACC_W:8]) begin
                    out_data_d = 8'd255;
                    out_sat_d  = 1'b1;
                end else begin
                    out_data_d = scaled[7:0];
                    out_sat_d  = 1'b0;
                end
                acc_d   = '0;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    state_d = ST_ACC;
                end
            end
            default: begin
                state_d = ST_ACC;
            end
        endcase
    end

    // State register; reset discards any partial sum and pending activation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_ACC;
            count_q    <= '0;
            acc_q      <= '0;
            out_data_q <= 8'd0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // The activation is valid exactly while the OUT state is held.
    assign bus.in_ready  = (state_q == ST_ACC);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// ---------------------------------------------------------------------------
// tb_neuron_accumulator
// Purpose : drives neuron_accumulator with directed and random product
//           streams and compares it every cycle with a transaction-level
//           model of the neuron (sum, bias, ReLU, shift, clip).
// ---------------------------------------------------------------------------
module tb_neuron_accumulator;

    localparam int NUM_INPUTS = 8;
    localparam int SHIFT      = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    neuron_accumulator_if bus ();

    neuron_accumulator #(
        .NUM_INPUTS (NUM_INPUTS),
        .ACC_W      (24),
        .SHIFT      (SHIFT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    // 0: random out_ready, 1: held low, 2: held high, 3: driven by the test
    int out_mode = 2;

    // Transaction-level model of the neuron.
    longint m_sum      = 0;
    int     m_count    = 0;
    bit     m_fin      = 1'b0;
    bit     m_out      = 1'b0;
    int     m_exp_data = 0;
    bit     m_exp_sat  = 1'b0;
    int     m_outputs  = 0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks_total++;
        if (actual == expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Activation as plain arithmetic on the full-precision sum.
    function automatic void activation(input longint sum, input longint b,
                                       output int act, output bit sat);
        longint r;
        r = sum + b;
        if (r < 0) begin
            act = 0;
            sat = 1'b0;
        end else if ((r >>> SHIFT) > 255) begin
            act = 255;
            sat = 1'b1;
        end else begin
            act = int'(r >>> SHIFT);
            sat = 1'b0;
        end
    endfunction

    // Model advance: a neuron takes NUM_INPUTS accepted products, then one
    // finishing cycle (bias taken there), then waits for the consumer.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_sum   = 0;
            m_count = 0;
            m_fin   = 1'b0;
            m_out   = 1'b0;
        end else if (m_out) begin
            if (bus.out_ready) begin
                m_out = 1'b0;
                m_outputs++;
            end
        end else if (m_fin) begin
            activation(m_sum, longint'($signed(bus.bias)), m_exp_data, m_exp_sat);
            m_sum = 0;
            m_fin = 1'b0;
            m_out = 1'b1;
        end else if (bus.in_valid) begin
            m_sum += longint'($signed(bus.in_data));
            m_count++;
            if (m_count == NUM_INPUTS) begin
                m_count = 0;
                m_fin   = 1'b1;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("rst_out_valid", bus.out_valid, 0);
            checkOutput("rst_out_data",  bus.out_data,  0);
            checkOutput("rst_out_sat",   bus.out_sat,   0);
            checkOutput("rst_in_ready",  bus.in_ready,  1);
        end else begin
            checkOutput("in_ready",  bus.in_ready,  (m_fin || m_out) ? 0 : 1);
            checkOutput("out_valid", bus.out_valid, m_out ? 1 : 0);
            if (m_out) begin
                checkOutput("out_data", bus.out_data, m_exp_data);
                checkOutput("out_sat",  bus.out_sat,  m_exp_sat);
            end
        end
    end

    // out_ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (out_mode)
            0:       bus.out_ready = 1'($urandom_range(0, 1));
            1:       bus.out_ready = 1'b0;
            2:       bus.out_ready = 1'b1;
            default: ;
        endcase
    end

    // Offer one product after an idle gap and hold it until accepted.
    // Entered and left just after a rising edge.
    task automatic applyStimulus(input logic [15:0] data, input int gap);
        bit took;
        int waited;
        took   = 1'b0;
        waited = 0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        while (!took) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
            waited++;
            if (!took && waited > 200) begin
                checkOutput("input_accept_timeout", 0, 1);
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 16'($urandom);
    endtask

    task automatic waitDrain();
        int c;
        c = 0;
        while ((m_fin || m_out) && c < 300) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 300) checkOutput("drain_timeout", 0, 1);
    endtask

    task automatic assertReset();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", bus.out_valid, 0);
        checkOutput("reset_out_data",  bus.out_data,  0);
        checkOutput("reset_out_sat",   bus.out_sat,   0);
        checkOutput("reset_in_ready",  bus.in_ready,  1);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // One neuron of identical products with literal expectations on timing
    // and on the activation; out_ready is high throughout.
    task automatic runDirected(input string name, input logic [15:0] data,
                               input logic [15:0] b, input int max_gap,
                               input int exp_data, input bit exp_sat);
        bus.bias = b;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            applyStimulus(data, $urandom_range(0, max_gap));
        end
        @(negedge clk);
        checkOutput({name, "_fin_out_valid"}, bus.out_valid, 0);
        checkOutput({name, "_fin_in_ready"},  bus.in_ready,  0);
        @(negedge clk);
        checkOutput({name, "_out_valid"}, bus.out_valid, 1);
        checkOutput({name, "_out_data"},  bus.out_data,  exp_data);
        checkOutput({name, "_out_sat"},   bus.out_sat,   exp_sat);
        @(posedge clk);
        #1;
        waitDrain();
    endtask

    initial begin
        int  act;
        bit  sat;
        int  c;

        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'd0;
        bus.bias      = 16'd0;
        bus.out_ready = 1'b1;

        // Pin the model's activation rule with hand-computed values.
        activation(800, 0, act, sat);
        checkOutput("model_800", act, 50);
        activation(-8000, 500, act, sat);
        checkOutput("model_neg", act, 0);
        activation(240000, 0, act, sat);
        checkOutput("model_clip", act, 255);
        checkOutput("model_clip_sat", sat, 1);
        activation(255 << 4, 0, act, sat);
        checkOutput("model_edge_sat", sat, 0);
        activation(256 << 4, 0, act, sat);
        checkOutput("model_over_sat", sat, 1);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Basic sum, negative sum clamped, large sum clipped.
        out_mode = 2;
        runDirected("t2",  16'd100,          16'd0,   0, 50,  1'b0);
        runDirected("t3",  16'(-1000),       16'd500, 0, 0,   1'b0);
        runDirected("t4",  16'd30000,        16'd0,   0, 255, 1'b1);
        // Boundaries: r = 0, r = 255<<SHIFT, r = 256<<SHIFT.
        runDirected("zero", 16'd0,           16'd0,   0, 0,   1'b0);
        runDirected("b255", 16'd510,         16'd0,   1, 255, 1'b0);
        runDirected("b256", 16'd512,         16'd0,   1, 255, 1'b1);

        // Reset mid-accumulation, then a fresh neuron with gaps.
        for (int i = 0; i < 3; i++) applyStimulus(16'd1000, 0);
        assertReset();
        runDirected("t6", 16'd16, 16'd16, 3, 9, 1'b0);

        // Reset while an activation is waiting in OUT.
        out_mode = 1;
        bus.bias = 16'd0;
        for (int i = 0; i < NUM_INPUTS; i++) applyStimulus(16'd100, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t1_out_pending", bus.out_valid, 1);
        assertReset();

        // Backpressure: activation held, next product offered but refused.
        out_mode = 3;
        bus.out_ready = 1'b0;
        bus.bias = 16'd0;
        for (int i = 0; i < NUM_INPUTS; i++) applyStimulus(16'd50, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'd7;
        c = 0;
        while (!bus.out_valid && c < 20) begin
            @(posedge clk);
            #1;
            c++;
        end
        checkOutput("t5_out_reached", bus.out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("t5_hold_valid",    bus.out_valid, 1);
            checkOutput("t5_hold_data",     bus.out_data,  25);
            checkOutput("t5_hold_in_ready", bus.in_ready,  0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_release_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("t5_after_in_ready",  bus.in_ready,  1);
        checkOutput("t5_after_out_valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkOutput("t5_product_taken", m_count, 1);
        for (int i = 1; i < NUM_INPUTS; i++) applyStimulus(16'd7, 0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("t5_next_data", bus.out_data, 3);
        @(posedge clk);
        #1;
        waitDrain();

        // Random products, biases, gaps and consumer stalls.
        out_mode = 0;
        for (int n = 0; n < 40; n++) begin
            bus.bias = 16'($urandom);
            for (int i = 0; i < NUM_INPUTS; i++) begin
                applyStimulus(16'($urandom), $urandom_range(0, 2));
                if ($urandom_range(0, 7) == 0) bus.bias = 16'($urandom_range(0, 4000));
            end
        end
        waitDrain();
        checkOutput("random_outputs_seen", (m_outputs >= 40) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
